pixel_streamer: RTL

Frame source for the CNN1 convolution datapath. It reads one image, stored row-major in a synchronous-read RAM with 1-cycle read latency, and emits it as a raster pixel stream on `pixel_in`/`pixel_valid`, the stream the `line_buffer` consumes. It honours the downstream `enable` as a stall and can optionally insert a zero border, so the conv layer can produce same-size outputs. It reports progress through `busy`, `done` and end-of-row/end-of-frame markers.

---
 rtl/cnn_pkg.sv | 28 ++
 rtl/raster_counter.sv | 74 +++++++
 rtl/pixel_streamer.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// -----------------------------------------------------------------------------
// cnn_pkg
// Shared definitions for the CNN1 datapath front end: default image geometry,
// pixel width, the frame-source state encoding and a counter-width helper.
// No ports (package).
// -----------------------------------------------------------------------------
package cnn_pkg;

    localparam int IMG_WIDTH_DEF  = 28;
    localparam int IMG_HEIGHT_DEF = 28;
    localparam int DATA_WIDTH_DEF = 8;

    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_ISSUE_ENC = 2'd1;
    localparam logic [1:0] ST_DRAIN_ENC = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_ISSUE = ST_ISSUE_ENC,
        ST_DRAIN = ST_DRAIN_ENC
    } state_t;

    // Bits needed to count 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/raster_counter.sv
// -----------------------------------------------------------------------------
// raster_counter
// Row/column position counter walking a ROWS x COLS raster in row-major order.
// Advances one position per cycle with i_advance, wraps to (0,0) after the
// last position, and can be synchronously cleared.
//   i_clk, i_rst_n  : clock, asynchronous active-low reset
//   i_clear         : synchronous return to (0,0); wins over i_advance
//   i_advance       : step to the next raster position
//   o_row, o_col    : current position
//   o_row_last      : current position is the last column of its row
//   o_frame_last    : current position is the last position of the raster
// -----------------------------------------------------------------------------
module raster_counter
    import cnn_pkg::*;
#(
    parameter int ROWS  = IMG_HEIGHT_DEF,
    parameter int COLS  = IMG_WIDTH_DEF,
    parameter int ROW_W = cnt_width(ROWS),
    parameter int COL_W = cnt_width(COLS)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_advance,
    output logic [ROW_W-1:0] o_row,
    output logic [COL_W-1:0] o_col,
    output logic             o_row_last,
    output logic             o_frame_last
);

    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;
    logic             w_row_last;
    logic             w_frame_last;

    // Flags decode the registered position, so they describe the position
    // being issued this cycle.
    always_comb begin
        w_row_last   = (r_col == COL_W'(COLS - 1));
        w_frame_last = w_row_last && (r_row == ROW_W'(ROWS - 1));
    end

    // Position register: clear, or step column-first with row/frame wrap.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_row <= {ROW_W{1'b0}};
            r_col <= {COL_W{1'b0}};
        end else if (i_clear) begin
            r_row <= {ROW_W{1'b0}};
            r_col <= {COL_W{1'b0}};
        end else if (i_advance) begin
            if (w_row_last) begin
                r_col <= {COL_W{1'b0}};
                if (w_frame_last) begin
                    r_row <= {ROW_W{1'b0}};
                end else begin
                    r_row <= r_row + {{(ROW_W-1){1'b0}}, 1'b1};
                end
            end else begin
                r_col <= r_col + {{(COL_W-1){1'b0}}, 1'b1};
                r_row <= r_row;
            end
        end else begin
            r_row <= r_row;
            r_col <= r_col;
        end
    end

    assign o_row        = r_row;
    assign o_col        = r_col;
    assign o_row_last   = w_row_last;
    assign o_frame_last = w_frame_last;

endmodule

// File: rtl/pixel_streamer.sv
// -----------------------------------------------------------------------------
// pixel_streamer
// Frame source for the CNN1 convolution datapath. Reads one row-major image
// from a 1-cycle-latency synchronous RAM and emits it as a raster pixel stream,
// optionally surrounded by a PAD-wide zero border, honouring `enable` as a
// downstream stall.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : level request for one frame, honoured only while idle
//   enable       : downstream ready; a beat transfers when pixel_valid=1
//   mem_rd_en    : RAM read strobe (interior positions only)
//   mem_addr     : RAM address, row*IMG_WIDTH + col of the stored image
//   mem_data     : RAM read data, valid the cycle after mem_rd_en
//   pixel_in     : streamed pixel (named after the line_buffer input)
//   pixel_valid  : beat valid, never high while enable=0
//   row_last     : beat is the last column of its emitted row
//   frame_last   : beat is the final beat of the frame
//   busy         : frame in progress
//   done         : one-cycle pulse in the cycle after the final beat
// -----------------------------------------------------------------------------
module pixel_streamer
    import cnn_pkg::*;
#(
    parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int PAD        = 0,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  enable,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic [DATA_WIDTH-1:0] pixel_in,
    output logic                  pixel_valid,
    output logic                  row_last,
    output logic                  frame_last,
    output logic                  busy,
    output logic                  done
);

    localparam int OUT_ROWS = IMG_HEIGHT + 2 * PAD;
    localparam int OUT_COLS = IMG_WIDTH + 2 * PAD;
    localparam int ROW_W    = cnt_width(OUT_ROWS);
    localparam int COL_W    = cnt_width(OUT_COLS);

    // Position counter outputs
    logic [ROW_W-1:0]      w_row;
    logic [COL_W-1:0]      w_col;
    logic                  w_pos_row_last;
    logic                  w_pos_frame_last;

    // Issue-side decode
    logic                  w_start_frame;
    logic                  w_issue;
    logic                  w_border;
    logic [ADDR_WIDTH-1:0] w_img_row;
    logic [ADDR_WIDTH-1:0] w_img_col;
    logic [ADDR_WIDTH-1:0] w_addr;

    // Return-side beat selection
    logic                  w_beat_vld;
    logic                  w_xfer;
    logic [DATA_WIDTH-1:0] w_s1_data;
    logic [DATA_WIDTH-1:0] w_beat_data;
    logic                  w_beat_row_last;
    logic                  w_beat_frame_last;

    // Control state
    state_t                r_state;
    logic                  r_busy;
    logic                  r_done;

    // Return stage: the position issued in the previous cycle
    logic                  r_s1_vld;
    logic                  r_s1_border;
    logic                  r_s1_row_last;
    logic                  r_s1_frame_last;

    // Hold register: a returned beat that met enable=0
    logic                  r_hold_vld;
    logic [DATA_WIDTH-1:0] r_hold_data;
    logic                  r_hold_row_last;
    logic                  r_hold_frame_last;

    raster_counter #(
        .ROWS  (OUT_ROWS),
        .COLS  (OUT_COLS),
        .ROW_W (ROW_W),
        .COL_W (COL_W)
    ) u_pos (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_clear      (w_start_frame),
        .i_advance    (w_issue),
        .o_row        (w_row),
        .o_col        (w_col),
        .o_row_last   (w_pos_row_last),
        .o_frame_last (w_pos_frame_last)
    );

    // A pending beat is always delivered in any cycle with enable=1, so with
    // enable=1 the stage is free for a new position in the same cycle. This
    // keeps a stall of N cycles costing exactly N cycles of throughput.
    always_comb begin
        w_start_frame = (r_state == ST_IDLE) && start;
        w_issue       = (r_state == ST_ISSUE) && enable;
    end

    // With PAD in {0,1} the border is exactly the outermost ring of the
    // emitted raster, so equality tests suffice and no underflowing
    // subtraction is ever compared.
    always_comb begin
        w_border = 1'b0;
        if (PAD != 0) begin
            w_border = (w_row == {ROW_W{1'b0}}) || (w_row == ROW_W'(OUT_ROWS - 1)) ||
                       (w_col == {COL_W{1'b0}}) || (w_col == COL_W'(OUT_COLS - 1));
        end else begin
            w_border = 1'b0;
        end
    end

    // Stored-image coordinates; only consumed for interior positions, where
    // the subtraction cannot wrap.
    always_comb begin
        w_img_row = ADDR_WIDTH'(w_row) - ADDR_WIDTH'(PAD);
        w_img_col = ADDR_WIDTH'(w_col) - ADDR_WIDTH'(PAD);
        w_addr    = (w_img_row * ADDR_WIDTH'(IMG_WIDTH)) + w_img_col;
    end

    // The read decision depends on this cycle's enable, so the strobe and
    // address are decoded from registered state plus enable.
    always_comb begin
        mem_rd_en = w_issue && !w_border;
        if (w_issue && !w_border) begin
            mem_addr = w_addr;
        end else begin
            mem_addr = {ADDR_WIDTH{1'b0}};
        end
    end

    // Select the beat on offer: the held beat first, else the returning one.
    // Stage and hold are never both valid, since nothing issues while a beat
    // sits undelivered.
    always_comb begin
        w_s1_data         = r_s1_border ? {DATA_WIDTH{1'b0}} : mem_data;
        w_beat_vld        = r_s1_vld || r_hold_vld;
        w_xfer            = w_beat_vld && enable;
        w_beat_data       = {DATA_WIDTH{1'b0}};
        w_beat_row_last   = 1'b0;
        w_beat_frame_last = 1'b0;
        if (r_hold_vld) begin
            w_beat_data       = r_hold_data;
            w_beat_row_last   = r_hold_row_last;
            w_beat_frame_last = r_hold_frame_last;
        end else if (r_s1_vld) begin
            w_beat_data       = w_s1_data;
            w_beat_row_last   = r_s1_row_last;
            w_beat_frame_last = r_s1_frame_last;
        end else begin
            w_beat_data       = {DATA_WIDTH{1'b0}};
            w_beat_row_last   = 1'b0;
            w_beat_frame_last = 1'b0;
        end
    end

    assign pixel_valid = w_xfer;
    assign pixel_in    = w_xfer ? w_beat_data : {DATA_WIDTH{1'b0}};
    assign row_last    = w_xfer && w_beat_row_last;
    assign frame_last  = w_xfer && w_beat_frame_last;

    // Return stage and hold register: tag each issued position, park a
    // returning beat that cannot transfer, release it when enable returns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld          <= 1'b0;
            r_s1_border       <= 1'b0;
            r_s1_row_last     <= 1'b0;
            r_s1_frame_last   <= 1'b0;
            r_hold_vld        <= 1'b0;
            r_hold_data       <= {DATA_WIDTH{1'b0}};
            r_hold_row_last   <= 1'b0;
            r_hold_frame_last <= 1'b0;
        end else begin
            r_s1_vld        <= w_issue;
            r_s1_border     <= w_border;
            r_s1_row_last   <= w_pos_row_last;
            r_s1_frame_last <= w_pos_frame_last;
            if (r_s1_vld && !enable) begin
                r_hold_vld        <= 1'b1;
                r_hold_data       <= w_s1_data;
                r_hold_row_last   <= r_s1_row_last;
                r_hold_frame_last <= r_s1_frame_last;
            end else if (r_hold_vld && enable) begin
                r_hold_vld        <= 1'b0;
                r_hold_data       <= r_hold_data;
                r_hold_row_last   <= r_hold_row_last;
                r_hold_frame_last <= r_hold_frame_last;
            end else begin
                r_hold_vld        <= r_hold_vld;
                r_hold_data       <= r_hold_data;
                r_hold_row_last   <= r_hold_row_last;
                r_hold_frame_last <= r_hold_frame_last;
            end
        end
    end

    // Frame control FSM with registered busy/done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state <= ST_ISSUE;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    r_done <= 1'b0;
                    r_busy <= 1'b1;
                    if (w_issue && w_pos_frame_last) begin
                        r_state <= ST_DRAIN;
                    end else begin
                        r_state <= ST_ISSUE;
                    end
                end
                ST_DRAIN: begin
                    // Only the final beat can be pending here.
                    if (w_xfer) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= ST_DRAIN;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;

endmodule
